mux_sel_arbiter: RTL and testbench

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter.sv | 102 ++++++++++
 tb/tb_mux_sel_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Two-source burst arbiter driving the enable/select of a downstream 2:1 mux.
// Each requester holds the grant for up to BURST consecutive cycles when the other is waiting.
module mux_sel_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  output logic       e,
  output logic       s,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] beat_cnt
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last;
  logic             last_nxt;

  // Next-state, next-count and fairness bookkeeping
  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req0 && (!req1 || last)) begin
          state_nxt = G0;
          last_nxt  = 1'b0;
        end else if (req1) begin
          state_nxt = G1;
          last_nxt  = 1'b1;
        end
      end
      G0: begin
        if (!req0 || (beat_cnt >= LAST_BEAT)) begin
          cnt_nxt = '0;
          if (req1) begin
            state_nxt = G1;
            last_nxt  = 1'b1;
          end else if (!req0) begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = CNT_W'(beat_cnt + CNT_W'(1));
        end
      end
      G1: begin
        if (!req1 || (beat_cnt >= LAST_BEAT)) begin
          cnt_nxt = '0;
          if (req0) begin
            state_nxt = G0;
            last_nxt  = 1'b0;
          end else if (!req1) begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = CNT_W'(beat_cnt + CNT_W'(1));
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // last resets to 1 so source 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      beat_cnt <= '0;
      e        <= 1'b0;
      s        <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      beat_cnt <= cnt_nxt;
      e        <= (state_nxt != IDLE);
      s        <= (state_nxt == G1);
      gnt0     <= (state_nxt == G0);
      gnt1     <= (state_nxt == G1);
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: BURST=4 instance for most scenarios, BURST=1 for alternation.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic       e, s, gnt0, gnt1;
  logic [3:0] beat_cnt;
  logic       b1_req0, b1_req1;
  logic       b1_e, b1_s, b1_gnt0, b1_gnt1;
  logic [3:0] b1_beat_cnt;

  int total;
  int bad;

  logic [7:0] obs;
  logic [7:0] exp_v;

  mux_sel_arbiter #(.BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .e(e), .s(s), .gnt0(gnt0), .gnt1(gnt1), .beat_cnt(beat_cnt)
  );

  mux_sel_arbiter #(.BURST(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .req0(b1_req0), .req1(b1_req1),
    .e(b1_e), .s(b1_s), .gnt0(b1_gnt0), .gnt1(b1_gnt1), .beat_cnt(b1_beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // One rising edge, then land on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; b1_req0 = 1'b0; b1_req1 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, 8'h00);
    end
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL idle_no_req: got %h want %h", obs, 8'h00);
    end
  endtask

  task automatic test_single();
    req0 = 1'b1; req1 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      obs   = {e, s, gnt0, gnt1, beat_cnt};
      exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 4'(i % 4)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL single_req0 cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    req0 = 1'b0;
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL single_release: got %h want %h", obs, 8'h00);
    end
  endtask

  task automatic test_both();
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic sx;
      step();
      sx    = 1'((i / 4) % 2);
      obs   = {e, s, gnt0, gnt1, beat_cnt};
      exp_v = {1'b1, sx, ~sx, sx, 4'(i % 4)};
      total++;
      if (obs !== exp_v || (gnt0 && gnt1)) begin
        bad++;
        $display("FAIL both_burst cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_drop_idle();
    req1 = 1'b1;
    step();
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'hD1) begin
      bad++;
      $display("FAIL g1_beat1: got %h want %h", obs, 8'hD1);
    end
    req1 = 1'b0;
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL g1_drop_to_idle: got %h want %h", obs, 8'h00);
    end
    req1 = 1'b1;
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'hD0) begin
      bad++;
      $display("FAIL g1_regrant: got %h want %h", obs, 8'hD0);
    end
  endtask

  task automatic test_handoff();
    req1 = 1'b0; req0 = 1'b1;
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'hA0) begin
      bad++;
      $display("FAIL g1_drop_to_g0: got %h want %h", obs, 8'hA0);
    end
    step();
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'hA2) begin
      bad++;
      $display("FAIL g0_beat2: got %h want %h", obs, 8'hA2);
    end
    req0 = 1'b0; req1 = 1'b1;
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'hD0) begin
      bad++;
      $display("FAIL g0_drop_to_g1: got %h want %h", obs, 8'hD0);
    end
  endtask

  task automatic test_async_reset();
    req0 = 1'b1; req1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL async_reset_now: got %h want %h", obs, 8'h00);
    end
    @(posedge clk);
    @(negedge clk);
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL reset_held_edge: got %h want %h", obs, 8'h00);
    end
    rst_n = 1'b1;
    step();
    obs = {e, s, gnt0, gnt1, beat_cnt};
    total++;
    if (obs !== 8'hA0) begin
      bad++;
      $display("FAIL post_reset_gnt0: got %h want %h", obs, 8'hA0);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_burst1();
    b1_req0 = 1'b1; b1_req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic sx;
      step();
      sx    = 1'(i % 2);
      obs   = {b1_e, b1_s, b1_gnt0, b1_gnt1, b1_beat_cnt};
      exp_v = {1'b1, sx, ~sx, sx, 4'd0};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL burst1_alt cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    b1_req0 = 1'b0; b1_req1 = 1'b0;
    step();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; b1_req0 = 1'b0; b1_req1 = 1'b0;
    total = 0;
    bad = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_both();
    test_drop_idle();
    test_handoff();
    test_async_reset();
    test_burst1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
